// File: rtl/gps_pps_qualifier.sv
// GPS PPS qualifier: synchronises the raw pulse, measures edge-to-edge intervals
// against a nominal window, and emits a strobe only for acceptable pulses.
module gps_pps_qualifier #(
  parameter int SYNC_STAGES   = 2,
  parameter int NOMINAL_COUNT = 10000000,
  parameter int TOLERANCE     = 2000,
  parameter int COUNT_WIDTH   = 28,
  parameter int LOCK_PULSES   = 3
) (
  input  logic                   system_clk,
  input  logic                   reset,
  input  logic                   gps_pulse,
  input  logic                   clear_flags,
  output logic                   pulse_strobe,
  output logic                   pulse_in_window,
  output logic                   locked,
  output logic                   missing_pulse,
  output logic                   spurious_pulse,
  output logic [COUNT_WIDTH-1:0] last_interval
);

  localparam logic [COUNT_WIDTH-1:0] WIN_LO  = COUNT_WIDTH'(NOMINAL_COUNT - TOLERANCE);
  localparam logic [COUNT_WIDTH-1:0] WIN_HI  = COUNT_WIDTH'(NOMINAL_COUNT + TOLERANCE);
  localparam logic [COUNT_WIDTH-1:0] MISS_AT = COUNT_WIDTH'(NOMINAL_COUNT + TOLERANCE + 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = {COUNT_WIDTH{1'b1}};
  localparam logic [3:0]             LOCK_N  = 4'(LOCK_PULSES);

  typedef enum logic [0:0] {
    ACQUIRE = 1'b0,
    TRACK   = 1'b1
  } state_t;

  state_t                 state_r;
  logic [SYNC_STAGES-1:0] sync_r;
  logic [SYNC_STAGES-1:0] valid_r;
  logic                   prev_r;
  logic                   armed_r;
  logic [COUNT_WIDTH-1:0] cnt_r;
  logic [3:0]             good_r;

  logic                   edge_s;
  logic                   in_window_s;
  logic                   timeout_s;
  logic [COUNT_WIDTH-1:0] cnt_inc_s;
  logic [3:0]             good_inc_s;

  // Synchroniser and edge-detect flop; armed_r blocks edges until a real low sample
  // has been seen, so a pin already high at reset release never produces an edge.
  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      sync_r  <= '0;
      valid_r <= '0;
      prev_r  <= 1'b0;
      armed_r <= 1'b0;
    end else begin
      sync_r  <= {sync_r[SYNC_STAGES-2:0], gps_pulse};
      valid_r <= {valid_r[SYNC_STAGES-2:0], 1'b1};
      prev_r  <= sync_r[SYNC_STAGES-1];
      armed_r <= armed_r | (valid_r[SYNC_STAGES-1] & ~sync_r[SYNC_STAGES-1]);
    end
  end

  // Edge detection, window compare and saturating increments.
  always_comb begin
    edge_s      = armed_r & sync_r[SYNC_STAGES-1] & ~prev_r;
    in_window_s = (cnt_r >= WIN_LO) && (cnt_r <= WIN_HI);
    timeout_s   = (cnt_r >= MISS_AT);
    if (cnt_r == CNT_MAX) begin
      cnt_inc_s = cnt_r;
    end else begin
      cnt_inc_s = cnt_r + CNT_ONE;
    end
    if (good_r >= LOCK_N) begin
      good_inc_s = LOCK_N;
    end else begin
      good_inc_s = good_r + 4'd1;
    end
  end

  // Qualification FSM with interval counter, lock tracking and sticky flags.
  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      state_r         <= ACQUIRE;
      cnt_r           <= '0;
      good_r          <= 4'd0;
      pulse_strobe    <= 1'b0;
      pulse_in_window <= 1'b0;
      locked          <= 1'b0;
      missing_pulse   <= 1'b0;
      spurious_pulse  <= 1'b0;
      last_interval   <= '0;
    end else begin
      pulse_strobe    <= 1'b0;
      pulse_in_window <= 1'b0;
      cnt_r           <= cnt_inc_s;
      // Clearing is applied first so a flag set later in this cycle wins.
      missing_pulse   <= missing_pulse & ~clear_flags;
      spurious_pulse  <= spurious_pulse & ~clear_flags;
      case (state_r)
        ACQUIRE: begin
          if (edge_s) begin
            pulse_strobe <= 1'b1;
            cnt_r        <= CNT_ONE;
            state_r      <= TRACK;
          end else begin
            state_r      <= ACQUIRE;
          end
        end
        TRACK: begin
          if (timeout_s) begin
            missing_pulse <= 1'b1;
            good_r        <= 4'd0;
            locked        <= 1'b0;
            state_r       <= ACQUIRE;
          end else if (edge_s && in_window_s) begin
            pulse_strobe    <= 1'b1;
            pulse_in_window <= 1'b1;
            last_interval   <= cnt_r;
            good_r          <= good_inc_s;
            locked          <= locked | (good_inc_s == LOCK_N);
            cnt_r           <= CNT_ONE;
          end else if (edge_s) begin
            // Early edge: ignored for timing, counter keeps running from the last good edge.
            spurious_pulse <= 1'b1;
            good_r         <= 4'd0;
            locked         <= 1'b0;
          end else begin
            state_r <= TRACK;
          end
        end
        default: begin
          state_r <= ACQUIRE;
          good_r  <= 4'd0;
          locked  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gps_pps_qualifier.sv
// Bench for gps_pps_qualifier: directed vector table, hand-written corner sequences,
// and random pulse trains checked every cycle against an interval-arithmetic model.
module tb_gps_pps_qualifier;

  localparam int SYNC = 2;
  localparam int NOM  = 100;
  localparam int TOL  = 5;
  localparam int CW   = 8;
  localparam int LOCK = 3;
  localparam int LO   = NOM - TOL;
  localparam int HI   = NOM + TOL;

  logic          clk;
  logic          reset;
  logic          gps_pulse;
  logic          clear_flags;
  logic          pulse_strobe;
  logic          pulse_in_window;
  logic          locked;
  logic          missing_pulse;
  logic          spurious_pulse;
  logic [CW-1:0] last_interval;

  gps_pps_qualifier #(
    .SYNC_STAGES(SYNC), .NOMINAL_COUNT(NOM), .TOLERANCE(TOL),
    .COUNT_WIDTH(CW), .LOCK_PULSES(LOCK)
  ) dut (
    .system_clk(clk), .reset(reset), .gps_pulse(gps_pulse), .clear_flags(clear_flags),
    .pulse_strobe(pulse_strobe), .pulse_in_window(pulse_in_window), .locked(locked),
    .missing_pulse(missing_pulse), .spurious_pulse(spurious_pulse),
    .last_interval(last_interval)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Cycle index since reset release; pin samples per cycle for the model.
  int n = 0;
  bit samp [0:16383];

  bit m_track;
  int m_good;
  int m_alast;
  int exp_strobe, exp_inwin, exp_locked, exp_missing, exp_spur, exp_last;

  typedef struct {
    int gap;
    int strobe;
    int inwin;
    int lock;
    int spur;
    int last;
  } vec_t;
  vec_t vecs [10];

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s cycle %0d actual %0d expected %0d", name, n, act, expv);
    end
  endtask

  task automatic goto(input int t);
    while (n < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model: intervals are differences of accepted-edge cycle indices.
  task automatic model_step();
    bit det;
    int d;
    if (reset) begin
      n = 0; m_track = 1'b0; m_good = 0; m_alast = 0;
      exp_strobe = 0; exp_inwin = 0; exp_locked = 0;
      exp_missing = 0; exp_spur = 0; exp_last = 0;
    end else begin
      n = n + 1;
      if (n < 16384) samp[n] = gps_pulse;
      exp_strobe = 0;
      exp_inwin  = 0;
      if (clear_flags) begin
        exp_missing = 0;
        exp_spur    = 0;
      end
      det = 1'b0;
      if (n >= SYNC + 2 && n < 16384) det = samp[n-SYNC] && !samp[n-SYNC-1];
      d = n - m_alast;
      if (!m_track) begin
        if (det) begin
          exp_strobe = 1; m_alast = n; m_track = 1'b1;
        end
      end else if (d > HI) begin
        exp_missing = 1; m_good = 0; exp_locked = 0; m_track = 1'b0;
      end else if (det) begin
        if (d >= LO) begin
          exp_strobe = 1; exp_inwin = 1; exp_last = d; m_alast = n;
          if (m_good < LOCK) m_good++;
          if (m_good == LOCK) exp_locked = 1;
        end else begin
          exp_spur = 1; m_good = 0; exp_locked = 0;
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("m_strobe", int'(pulse_strobe), exp_strobe);
      chk("m_inwin", int'(pulse_in_window), exp_inwin);
      chk("m_locked", int'(locked), exp_locked);
      chk("m_missing", int'(missing_pulse), exp_missing);
      chk("m_spurious", int'(spurious_pulse), exp_spur);
      chk("m_last", int'(last_interval), exp_last);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cycle %0d actual timeout expected finish", n);
    $fatal(1);
  end

  initial begin
    int t, s, r1, r2, r3, gap, hi, c, cnt;
    vecs[0] = '{100, 1, 0, 0, 0, 0};
    vecs[1] = '{100, 1, 1, 0, 0, 100};
    vecs[2] = '{100, 1, 1, 0, 0, 100};
    vecs[3] = '{100, 1, 1, 1, 0, 100};
    vecs[4] = '{105, 1, 1, 1, 0, 105};
    vecs[5] = '{95,  1, 1, 1, 0, 95};
    vecs[6] = '{50,  0, 0, 0, 1, 95};
    vecs[7] = '{50,  1, 1, 0, 1, 100};
    vecs[8] = '{100, 1, 1, 0, 1, 100};
    vecs[9] = '{100, 1, 1, 1, 1, 100};

    reset = 1'b1; gps_pulse = 1'b0; clear_flags = 1'b0;
    @(negedge clk);
    chk("rst_strobe", int'(pulse_strobe), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_last", int'(last_interval), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    t = 0;
    for (int i = 0; i < 10; i++) begin
      t += vecs[i].gap;
      goto(t);
      gps_pulse = 1'b1;
      goto(t + SYNC + 1);
      @(negedge clk);
      chk($sformatf("vec%0d_strobe", i), int'(pulse_strobe), vecs[i].strobe);
      chk($sformatf("vec%0d_inwin", i), int'(pulse_in_window), vecs[i].inwin);
      chk($sformatf("vec%0d_locked", i), int'(locked), vecs[i].lock);
      chk($sformatf("vec%0d_spurious", i), int'(spurious_pulse), vecs[i].spur);
      chk($sformatf("vec%0d_last", i), int'(last_interval), vecs[i].last);
      goto(t + 10);
      gps_pulse = 1'b0;
    end

    // Pin stops while locked: missing exactly HI+1 cycles after the counter restart.
    s = t + SYNC + 1;
    goto(s + HI);
    @(negedge clk);
    chk("miss_before", int'(missing_pulse), 0);
    chk("miss_before_locked", int'(locked), 1);
    goto(s + HI + 1);
    @(negedge clk);
    chk("miss_at", int'(missing_pulse), 1);
    chk("miss_at_locked", int'(locked), 0);

    r1 = s + 150;
    goto(r1);
    gps_pulse = 1'b1;
    goto(r1 + SYNC + 1);
    @(negedge clk);
    chk("reacq_strobe", int'(pulse_strobe), 1);
    chk("reacq_inwin", int'(pulse_in_window), 0);
    chk("reacq_last", int'(last_interval), 100);
    goto(r1 + 10);
    gps_pulse = 1'b0;

    // Clear coinciding with a spurious event, then a lone clear.
    r2 = r1 + 50;
    goto(r2);
    gps_pulse = 1'b1;
    goto(r2 + SYNC);
    clear_flags = 1'b1;
    goto(r2 + SYNC + 1);
    clear_flags = 1'b0;
    @(negedge clk);
    chk("clr_set_spurious", int'(spurious_pulse), 1);
    chk("clr_set_missing", int'(missing_pulse), 0);
    chk("clr_set_strobe", int'(pulse_strobe), 0);
    goto(r2 + SYNC + 2);
    clear_flags = 1'b1;
    goto(r2 + SYNC + 3);
    clear_flags = 1'b0;
    @(negedge clk);
    chk("clr_only_spurious", int'(spurious_pulse), 0);
    chk("clr_only_missing", int'(missing_pulse), 0);
    goto(r2 + 10);
    gps_pulse = 1'b0;

    // Reset mid-interval with the pin held high: no strobe until a fresh rise.
    r3 = r2 + 30;
    goto(r3);
    gps_pulse = 1'b1;
    goto(r3 + 20);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_strobe", int'(pulse_strobe), 0);
    chk("midrst_spurious", int'(spurious_pulse), 0);
    chk("midrst_last", int'(last_interval), 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    cnt = 0;
    for (int k = 1; k <= 150; k++) begin
      goto(k);
      @(negedge clk);
      if (pulse_strobe) cnt++;
    end
    chk("high_at_release_strobes", cnt, 0);
    gps_pulse = 1'b0;
    goto(200);
    gps_pulse = 1'b1;
    goto(200 + SYNC + 1);
    @(negedge clk);
    chk("post_rst_strobe", int'(pulse_strobe), 1);
    chk("post_rst_inwin", int'(pulse_in_window), 0);

    // Pin held high after an accepted edge: missing at HI+1.
    goto(200 + SYNC + 1 + HI);
    @(negedge clk);
    chk("held_before", int'(missing_pulse), 0);
    goto(200 + SYNC + 1 + HI + 1);
    @(negedge clk);
    chk("held_missing", int'(missing_pulse), 1);
    goto(320);
    gps_pulse = 1'b0;

    // Random pulse trains, biased toward the window boundaries.
    t = 320;
    repeat (60) begin
      if ($urandom_range(0, 1) == 0) gap = $urandom_range(LO - 2, HI + 2);
      else gap = $urandom_range(40, 130);
      t += gap;
      hi = $urandom_range(1, 30);
      goto(t);
      gps_pulse = 1'b1;
      goto(t + hi);
      gps_pulse = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        c = t + hi + $urandom_range(1, 5);
        goto(c);
        clear_flags = 1'b1;
        goto(c + 1);
        clear_flags = 1'b0;
      end
    end
    goto(t + 250);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gps_pps_qualifier.md
Name: gps_pps_qualifier

Overview:
- Conditions the raw GPS_PULSE pin before it reaches the GPS-gated frequency counter.
- Synchronises the pulse and detects its rising edge. Measures each edge-to-edge interval in system_clk cycles and checks it against a nominal window.
- Emits a one-cycle strobe only for acceptable pulses, plus lock status and sticky missing/spurious flags for SPI readout.
- The downstream counter gates on pulse_strobe instead of its ad-hoc 4-bit stabiliser.

Parameters:
- SYNC_STAGES, 2: synchroniser flops on gps_pulse (minimum 2).
- NOMINAL_COUNT, 10000000: expected system_clk cycles between PPS edges.
- TOLERANCE, 2000: allowed absolute deviation from NOMINAL_COUNT, in cycles.
- COUNT_WIDTH, 28: width of the interval counter and last_interval. Must hold NOMINAL_COUNT+TOLERANCE+1.
- LOCK_PULSES, 3: consecutive in-window intervals required to assert locked (1..15).

Ports:
- system_clk  in  1  sole clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- gps_pulse  in  1  raw, asynchronous PPS pin.
- clear_flags  in  1  one-cycle pulse; clears missing_pulse and spurious_pulse.
- pulse_strobe  out  1  one-cycle pulse per accepted PPS edge.
- pulse_in_window  out  1  valid with pulse_strobe; 1 when the measured interval was in window.
- locked  out  1  high while tracking LOCK_PULSES or more consecutive good intervals.
- missing_pulse  out  1  sticky; an expected edge did not arrive in time.
- spurious_pulse  out  1  sticky; an edge arrived too early.
- last_interval  out  COUNT_WIDTH  interval of the most recent accepted edge after the first.

Behaviour:
- Reset: all outputs are 0, the synchroniser is cleared, interval counter = 0, good counter = 0, state = ACQUIRE.
- Synchroniser: SYNC_STAGES flops, then one edge-detect flop. A rising edge is seen SYNC_STAGES+1 cycles after the pin rises.
- pulse_strobe and pulse_in_window are registered. pulse_strobe asserts exactly SYNC_STAGES+1 cycles after the pin edge, for 1 cycle.
- Interval counter:
  - Loads 1 in the cycle after an accepted edge, then increments each cycle.
  - Saturates at all-ones; it never wraps.
  - D = counter value in the cycle the edge is detected.
  - LO = NOMINAL_COUNT-TOLERANCE, HI = NOMINAL_COUNT+TOLERANCE. Window is LO <= D <= HI, both bounds inclusive.
- State ACQUIRE:
  - Counter is running but not checked.
  - First detected edge: strobe with pulse_in_window=0, counter restarts, last_interval unchanged, -> TRACK.
- State TRACK:
  - Edge with D in window: strobe, pulse_in_window=1, last_interval<=D, good counter +1, counter restarts. If the good counter reaches LOCK_PULSES, locked<=1 (same update cycle as the strobe).
  - Edge with D < LO: spurious. No strobe, counter NOT restarted (edge ignored), spurious_pulse<=1, good counter <= 0, locked <= 0. State stays TRACK.
  - Counter reaching HI+1 with no edge: missing_pulse<=1, good counter <= 0, locked <= 0, -> ACQUIRE. The counter keeps running.
- The good counter saturates at LOCK_PULSES.
- Simultaneous clear_flags and a flag-setting event in the same cycle: the set wins.
- An edge in the same cycle the counter reaches HI+1 is treated as missing: the transition to ACQUIRE wins and the edge is not accepted.
- Asserting reset mid-interval aborts immediately. After release the block starts in ACQUIRE; no strobe is generated from a pin level already high at release without a new rising edge.
- gps_pulse held high produces no further edges; missing fires at HI+1.

Test Plan:
- Reset, then first pin rise at cycle 100 (SYNC_STAGES=2) -> pulse_strobe at cycle 103, pulse_in_window=0, locked=0, last_interval=0.
- Small params (NOMINAL=100, TOL=5, LOCK=3): four edges spaced 100 cycles -> strobes 2-4 have pulse_in_window=1, last_interval=100, locked rises with the 4th strobe.
- Locked, then next edge at spacing 105, then 95 -> both accepted and in window; the boundaries are inclusive.
- Locked, then an extra edge 50 cycles after the last one -> no strobe, spurious_pulse=1, locked=0. The following edge at 100 from the last accepted edge is accepted with last_interval=100.
- Locked, then pin stops -> missing_pulse=1 and locked=0 exactly 106 cycles after the last accepted edge's counter restart, state ACQUIRE. The next edge gives a strobe with pulse_in_window=0.
- clear_flags asserted in the same cycle as a new spurious event -> spurious_pulse stays 1. clear_flags alone one cycle later -> both flags are 0.
